// File: rtl/assoc_store_pkg.sv
// assoc_store_pkg
//   Shared definitions for the associative key/value store:
//   - request opcode encodings (3 bits; codes 6..7 behave as NONE)
//   - entry field width helper
//   - count-width helper used to size the occupancy output
package assoc_store_pkg;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_LOOKUP = 3'd1,
    OP_WRITE  = 3'd2,
    OP_INCR   = 3'd3,
    OP_DELETE = 3'd4,
    OP_FLUSH  = 3'd5
  } op_e;

  // Bits held by one entry: valid + key + data.
  function automatic int entry_bits(input int key_width, input int data_width);
    return 1 + key_width + data_width;
  endfunction

  // Occupancy must be able to represent 0..entries inclusive.
  function automatic int cnt_width(input int entries);
    return $clog2(entries + 1);
  endfunction

endpackage

// File: rtl/assoc_store_entry.sv
// assoc_store_entry
//   One storage slot of the associative store.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     i_clr           invalidate the slot (highest priority)
//     i_load          write {i_key, i_data} and mark valid
//     i_inc           increment stored data (wraps)
//     i_key, i_data   load values
//     i_cmp_key       key compared against the stored key
//     o_valid/o_key/o_data  slot contents
//     o_match         o_valid && stored key == i_cmp_key
module assoc_store_entry #(
  parameter int KEY_WIDTH  = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic                  i_inc,
  input  logic [KEY_WIDTH-1:0]  i_key,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [KEY_WIDTH-1:0]  i_cmp_key,
  output logic                  o_valid,
  output logic [KEY_WIDTH-1:0]  o_key,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_match
);

  logic                  r_valid;
  logic [KEY_WIDTH-1:0]  r_key;
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_key   <= '0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_key   <= i_key;
      r_data  <= i_data;
    end else if (i_inc) begin
      r_data <= r_data + DATA_WIDTH'(1);
    end
  end

  assign o_valid = r_valid;
  assign o_key   = r_key;
  assign o_data  = r_data;
  assign o_match = r_valid && (r_key == i_cmp_key);

endmodule

// File: rtl/assoc_store.sv
// assoc_store
//   Associative key/value store with a registered single-cycle response.
//   Ops: LOOKUP, WRITE, INCR, DELETE, FLUSH. Optional round-robin eviction
//   when a WRITE/INCR misses on a full store (EVICT=1), otherwise rejected.
//   Ports:
//     clk, rst             clock, asynchronous active-low reset
//     req_valid/op/key/data  request, one per cycle, no backpressure
//     rsp_valid            one-cycle strobe after an accepted request
//     rsp_hit/ok/data      response fields (hold when no response)
//     count, full          registered occupancy after the op
module assoc_store
  import assoc_store_pkg::*;
#(
  parameter int KEY_WIDTH  = 5,
  parameter int DATA_WIDTH = 8,
  parameter int ENTRIES    = 16,
  parameter int EVICT      = 1,
  localparam int CNT_WIDTH = cnt_width(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [2:0]            req_op,
  input  logic [KEY_WIDTH-1:0]  req_key,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic                  rsp_ok,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0]    w_match;
  logic [ENTRIES-1:0]    w_valid;
  logic [ENTRIES-1:0]    w_clr;
  logic [ENTRIES-1:0]    w_load;
  logic [ENTRIES-1:0]    w_inc;
  logic [KEY_WIDTH-1:0]  w_key  [ENTRIES];
  logic [DATA_WIDTH-1:0] w_data [ENTRIES];
  logic [DATA_WIDTH-1:0] w_load_data;

  logic                  w_hit;
  logic [IDX_W-1:0]      w_hit_idx;
  logic                  w_has_free;
  logic [IDX_W-1:0]      w_free_idx;
  logic [DATA_WIDTH-1:0] w_hit_data;

  logic                  w_accept;
  logic                  w_nxt_hit;
  logic                  w_nxt_ok;
  logic [DATA_WIDTH-1:0] w_nxt_data;
  logic [CNT_WIDTH-1:0]  w_nxt_count;
  logic [IDX_W-1:0]      w_nxt_ptr;

  logic                  r_rsp_valid;
  logic                  r_rsp_hit;
  logic                  r_rsp_ok;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_full;
  logic [IDX_W-1:0]      r_ptr;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    assoc_store_entry #(
      .KEY_WIDTH (KEY_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst),
      .i_clr    (w_clr[g]),
      .i_load   (w_load[g]),
      .i_inc    (w_inc[g]),
      .i_key    (req_key),
      .i_data   (w_load_data),
      .i_cmp_key(req_key),
      .o_valid  (w_valid[g]),
      .o_key    (w_key[g]),
      .o_data   (w_data[g]),
      .o_match  (w_match[g])
    );
  end

  // Priority encoders: lowest-index match and lowest-index free slot.
  // Scanning downward lets the lowest index win.
  always_comb begin
    w_hit      = |w_match;
    w_has_free = ~&w_valid;
    w_hit_idx  = '0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_idx = IDX_W'(i);
      if (!w_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  assign w_hit_data = w_data[w_hit_idx];

  always_comb begin
    w_clr       = '0;
    w_load      = '0;
    w_inc       = '0;
    w_load_data = req_data;
    w_accept    = 1'b0;
    w_nxt_hit   = 1'b0;
    w_nxt_ok    = 1'b0;
    w_nxt_data  = '0;
    w_nxt_count = r_count;
    w_nxt_ptr   = r_ptr;
    if (req_valid) begin
      case (req_op)
        OP_LOOKUP: begin
          w_accept  = 1'b1;
          w_nxt_hit = w_hit;
          w_nxt_ok  = w_hit;
          if (w_hit) w_nxt_data = w_hit_data;
        end
        OP_WRITE, OP_INCR: begin
          w_accept    = 1'b1;
          w_nxt_hit   = w_hit;
          // A missing INCR key is inserted with count 1.
          w_load_data = (req_op == OP_INCR) ? DATA_WIDTH'(1) : req_data;
          if (w_hit) begin
            w_nxt_ok = 1'b1;
            if (req_op == OP_INCR) begin
              w_inc[w_hit_idx] = 1'b1;
              w_nxt_data       = w_hit_data + DATA_WIDTH'(1);
            end else begin
              w_load[w_hit_idx] = 1'b1;
              w_nxt_data        = w_hit_data;
            end
          end else if (w_has_free) begin
            w_nxt_ok           = 1'b1;
            w_load[w_free_idx] = 1'b1;
            w_nxt_count        = r_count + CNT_WIDTH'(1);
            w_nxt_data         = (req_op == OP_INCR) ? DATA_WIDTH'(1) : '0;
          end else if (EVICT != 0) begin
            w_nxt_ok      = 1'b1;
            w_load[r_ptr] = 1'b1;
            w_nxt_ptr     = (r_ptr == IDX_W'(ENTRIES - 1)) ? '0 : r_ptr + IDX_W'(1);
            w_nxt_data    = (req_op == OP_INCR) ? DATA_WIDTH'(1) : w_data[r_ptr];
          end
        end
        OP_DELETE: begin
          w_accept  = 1'b1;
          w_nxt_hit = w_hit;
          w_nxt_ok  = w_hit;
          if (w_hit) begin
            w_clr[w_hit_idx] = 1'b1;
            w_nxt_data       = w_hit_data;
            w_nxt_count      = r_count - CNT_WIDTH'(1);
          end
        end
        OP_FLUSH: begin
          w_accept    = 1'b1;
          w_nxt_ok    = 1'b1;
          w_clr       = '1;
          w_nxt_count = '0;
          w_nxt_ptr   = '0;
        end
        default: ;
      endcase
    end
  end

  // Response fields hold their last value when no request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_ok    <= 1'b0;
      r_rsp_data  <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_ptr       <= '0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_rsp_hit  <= w_nxt_hit;
        r_rsp_ok   <= w_nxt_ok;
        r_rsp_data <= w_nxt_data;
        r_count    <= w_nxt_count;
        r_full     <= (w_nxt_count == CNT_WIDTH'(ENTRIES));
        r_ptr      <= w_nxt_ptr;
      end
    end
  end

  // At most one valid entry per key, and the hit slot really holds req_key.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert ($onehot0(w_match));
      assert (!w_hit || (w_key[w_hit_idx] == req_key));
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_ok    = r_rsp_ok;
  assign rsp_data  = r_rsp_data;
  assign count     = r_count;
  assign full      = r_full;

endmodule

// File: tb/tb_assoc_store.sv
// tb_assoc_store
//   Drives two 4-entry stores (EVICT=1 and EVICT=0) with the same request
//   stream. A behavioural model predicts each response; predictions are
//   queued when a request is driven and compared when the response is due.
module tb_assoc_store;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_op = 3'd0;
  logic [4:0] req_key = '0;
  logic [7:0] req_data = '0;

  logic       ev_rsp_valid, ev_rsp_hit, ev_rsp_ok, ev_full;
  logic [7:0] ev_rsp_data;
  logic [2:0] ev_count;
  logic       rj_rsp_valid, rj_rsp_hit, rj_rsp_ok, rj_full;
  logic [7:0] rj_rsp_data;
  logic [2:0] rj_count;

  always #5 clk = ~clk;

  assoc_store #(.KEY_WIDTH(5), .DATA_WIDTH(8), .ENTRIES(N), .EVICT(1)) u_dut_ev (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(ev_rsp_valid), .rsp_hit(ev_rsp_hit), .rsp_ok(ev_rsp_ok),
    .rsp_data(ev_rsp_data), .count(ev_count), .full(ev_full)
  );

  assoc_store #(.KEY_WIDTH(5), .DATA_WIDTH(8), .ENTRIES(N), .EVICT(0)) u_dut_rj (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(rj_rsp_valid), .rsp_hit(rj_rsp_hit), .rsp_ok(rj_rsp_ok),
    .rsp_data(rj_rsp_data), .count(rj_count), .full(rj_full)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic       vld;
    logic       hit;
    logic       ok;
    logic [7:0] data;
    int         cnt;
    logic       full;
  } exp_t;

  exp_t q_ev[$];
  exp_t q_rj[$];

  // Model state, index 0 = evicting store, 1 = rejecting store.
  logic       m_v [2][N];
  logic [4:0] m_k [2][N];
  logic [7:0] m_d [2][N];
  int         m_ptr [2];
  int         m_cnt [2];
  exp_t       m_prev [2];

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < N; i++) begin
        m_v[s][i] = 1'b0;
        m_k[s][i] = '0;
        m_d[s][i] = '0;
      end
      m_ptr[s] = 0;
      m_cnt[s] = 0;
      m_prev[s] = '{vld: 1'b0, hit: 1'b0, ok: 1'b0, data: 8'd0, cnt: 0, full: 1'b0};
    end
  endtask

  task automatic model_step(input int s, input logic vld, input logic [2:0] op,
                            input logic [4:0] key, input logic [7:0] data,
                            output exp_t e);
    int hi;
    int fr;
    int tgt;
    hi = -1;
    fr = -1;
    for (int i = 0; i < N; i++) begin
      if (hi < 0 && m_v[s][i] && m_k[s][i] == key) hi = i;
      if (fr < 0 && !m_v[s][i]) fr = i;
    end
    e = m_prev[s];
    e.vld = 1'b0;
    if (vld && op >= 3'd1 && op <= 3'd5) begin
      e.vld = 1'b1;
      case (op)
        3'd1: begin
          e.hit = (hi >= 0);
          e.ok = e.hit;
          e.data = (hi >= 0) ? m_d[s][hi] : 8'd0;
        end
        3'd2, 3'd3: begin
          e.hit = (hi >= 0);
          if (hi >= 0) begin
            e.ok = 1'b1;
            if (op == 3'd3) begin
              m_d[s][hi] = m_d[s][hi] + 8'd1;
              e.data = m_d[s][hi];
            end else begin
              e.data = m_d[s][hi];
              m_d[s][hi] = data;
            end
          end else begin
            tgt = -1;
            e.data = 8'd0;
            if (fr >= 0) begin
              tgt = fr;
              m_cnt[s]++;
            end else if (s == 0) begin
              tgt = m_ptr[s];
              e.data = m_d[s][tgt];
              m_ptr[s] = (m_ptr[s] + 1) % N;
            end
            if (tgt >= 0) begin
              e.ok = 1'b1;
              m_v[s][tgt] = 1'b1;
              m_k[s][tgt] = key;
              m_d[s][tgt] = (op == 3'd3) ? 8'd1 : data;
              if (op == 3'd3) e.data = 8'd1;
            end else begin
              e.ok = 1'b0;
              e.data = 8'd0;
            end
          end
        end
        3'd4: begin
          e.hit = (hi >= 0);
          e.ok = e.hit;
          e.data = 8'd0;
          if (hi >= 0) begin
            e.data = m_d[s][hi];
            m_v[s][hi] = 1'b0;
            m_cnt[s]--;
          end
        end
        default: begin
          for (int i = 0; i < N; i++) m_v[s][i] = 1'b0;
          m_ptr[s] = 0;
          m_cnt[s] = 0;
          e.hit = 1'b0;
          e.ok = 1'b1;
          e.data = 8'd0;
        end
      endcase
    end
    e.cnt = m_cnt[s];
    e.full = (m_cnt[s] == N);
    m_prev[s] = e;
  endtask

  // One request per cycle; inputs change 3 time units after the edge.
  task automatic req(input logic vld, input logic [2:0] op,
                     input logic [4:0] key, input logic [7:0] data);
    exp_t e0;
    exp_t e1;
    @(posedge clk);
    #3;
    req_valid = vld;
    req_op = op;
    req_key = key;
    req_data = data;
    model_step(0, vld, op, key, data, e0);
    model_step(1, vld, op, key, data, e1);
    q_ev.push_back(e0);
    q_rj.push_back(e1);
  endtask

  task automatic compare(input string nm, input exp_t e, input logic v, input logic h,
                         input logic o, input logic [7:0] d, input logic [2:0] c,
                         input logic f);
    check_val({nm, ".valid"}, int'(v), int'(e.vld));
    check_val({nm, ".hit"}, int'(h), int'(e.hit));
    check_val({nm, ".ok"}, int'(o), int'(e.ok));
    check_val({nm, ".data"}, int'(d), int'(e.data));
    check_val({nm, ".count"}, int'(c), e.cnt);
    check_val({nm, ".full"}, int'(f), int'(e.full));
  endtask

  // Responses registered at the edge are checked 1 unit later.
  always @(posedge clk) begin
    #1;
    if (rst && q_ev.size() > 0 && q_rj.size() > 0) begin
      compare("ev", q_ev.pop_front(), ev_rsp_valid, ev_rsp_hit, ev_rsp_ok,
              ev_rsp_data, ev_count, ev_full);
      compare("rj", q_rj.pop_front(), rj_rsp_valid, rj_rsp_hit, rj_rsp_ok,
              rj_rsp_data, rj_count, rj_full);
    end
  end

  task automatic check_outputs_zero(input string nm);
    check_val({nm, ".ev_valid"}, int'(ev_rsp_valid), 0);
    check_val({nm, ".ev_hit"}, int'(ev_rsp_hit), 0);
    check_val({nm, ".ev_ok"}, int'(ev_rsp_ok), 0);
    check_val({nm, ".ev_data"}, int'(ev_rsp_data), 0);
    check_val({nm, ".ev_count"}, int'(ev_count), 0);
    check_val({nm, ".ev_full"}, int'(ev_full), 0);
    check_val({nm, ".rj_valid"}, int'(rj_rsp_valid), 0);
    check_val({nm, ".rj_data"}, int'(rj_rsp_data), 0);
    check_val({nm, ".rj_count"}, int'(rj_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check_outputs_zero("reset");
    rst = 1'b1;

    // Basic lookup / write / increment with wrap.
    req(1, 3'd1, 5'd3, 8'h00);
    req(1, 3'd2, 5'd3, 8'h5A);
    req(1, 3'd1, 5'd3, 8'h00);
    req(1, 3'd2, 5'd3, 8'hFF);
    req(1, 3'd3, 5'd3, 8'h00);
    req(1, 3'd3, 5'd3, 8'h00);
    req(1, 3'd5, 5'd0, 8'h00);
    req(1, 3'd3, 5'd9, 8'h00);
    req(1, 3'd5, 5'd0, 8'h00);

    // Fill, then evict (or reject), and pointer advance.
    for (int k = 1; k <= 4; k++) req(1, 3'd2, 5'(k), 8'(k * 17));
    req(1, 3'd2, 5'd5, 8'h55);
    req(1, 3'd1, 5'd1, 8'h00);
    req(1, 3'd2, 5'd6, 8'h66);
    req(1, 3'd1, 5'd5, 8'h00);
    req(1, 3'd3, 5'd7, 8'h00);
    req(1, 3'd3, 5'd10, 8'h00);
    req(1, 3'd6, 5'd3, 8'h00);
    req(0, 3'd1, 5'd3, 8'h00);
    req(1, 3'd0, 5'd3, 8'h00);

    // Delete, reuse of freed slot, flush.
    req(1, 3'd5, 5'd0, 8'h00);
    for (int k = 1; k <= 4; k++) req(1, 3'd2, 5'(k), 8'(k * 17));
    req(1, 3'd4, 5'd2, 8'h00);
    req(1, 3'd4, 5'd2, 8'h00);
    req(1, 3'd2, 5'd7, 8'h77);
    req(1, 3'd1, 5'd7, 8'h00);
    req(1, 3'd4, 5'd9, 8'h00);
    req(1, 3'd5, 5'd0, 8'h00);
    for (int k = 1; k <= 4; k++) req(1, 3'd1, 5'(k), 8'h00);

    // Back-to-back write then lookup.
    req(1, 3'd2, 5'd8, 8'h10);
    req(1, 3'd1, 5'd8, 8'h00);

    // Random mix over a small key space so hits, evictions and rejects occur.
    for (int n = 0; n < 400; n++) begin
      req(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end

    // Reset in the middle of a WRITE: no response, outputs cleared at once.
    req(1, 3'd2, 5'd8, 8'h10);
    @(posedge clk);
    #3;
    req_valid = 1'b1;
    req_op = 3'd2;
    req_key = 5'd12;
    req_data = 8'hAB;
    #1;
    rst = 1'b0;
    #1;
    check_outputs_zero("midreset");
    req_valid = 1'b0;
    @(posedge clk);
    #3;
    model_reset();
    rst = 1'b1;
    req(0, 3'd0, 5'd0, 8'h00);
    req(1, 3'd1, 5'd12, 8'h00);
    req(1, 3'd1, 5'd8, 8'h00);
    req(0, 3'd0, 5'd0, 8'h00);

    for (int w = 0; w < 10 && q_ev.size() > 0; w++) @(posedge clk);
    #2;
    check_val("drain", q_ev.size() + q_rj.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
